// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared constants and FSM state type for the SPI flash reader.
package spi_flash_pkg;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam int ADDR_BITS = 24;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STALL, CSH} state_t;
endpackage

// File: rtl/spi_sclk_div.sv
// spi_sclk_div: SCLK half-period divider with freeze (en_i low) and clear.
module spi_sclk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic rise_en_o,
    output logic fall_en_o,
    output logic sclk_o
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic sclk_q, sclk_d;
    logic tick;
    assign tick = en_i && cnt_q == CW'(CLK_DIV - 1);
    // rise_en_o is the would-be rise; the owner may cancel it with clr_i
    assign rise_en_o = tick && !sclk_q;
    assign fall_en_o = tick && sclk_q;
    assign sclk_o = sclk_q;
    always_comb begin
        cnt_d = clr_i ? '0 : !en_i ? cnt_q : tick ? '0 : cnt_q + 1'b1;
        sclk_d = clr_i ? 1'b0 : tick ? !sclk_q : sclk_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sclk_q <= sclk_d;
        end
    end
endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI mode-0 master issuing READ + 24-bit address and
// streaming received bytes out on a valid/ready interface with backpressure.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int LEN_W = 22,
    parameter int CSH_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 req_ready,
    input  logic [23:0]          addr,
    input  logic [LEN_W-1:0]     len,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 flash_csn,
    output logic                 flash_sclk,
    output logic                 flash_mosi,
    input  logic                 flash_miso
);
    localparam int HW = CSH_CYCLES > 1 ? $clog2(CSH_CYCLES + 1) : 1;
    state_t state_q, state_d;
    logic [ADDR_BITS+7:0] sh_q, sh_d;
    logic [4:0] bit_q, bit_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] out_data_q, out_data_d;
    logic out_valid_q, out_valid_d;
    logic csn_q, csn_d;
    logic done_q, done_d;
    logic [HW-1:0] csh_q, csh_d;
    logic div_en, div_clr, rise, fall;

    assign div_en = state_q inside {CMD, ADDR, DATA};

    spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .reset    (reset),
        .en_i     (div_en),
        .clr_i    (div_clr),
        .rise_en_o(rise),
        .fall_en_o(fall),
        .sclk_o   (flash_sclk)
    );

    assign req_ready = state_q == IDLE;
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign flash_csn = csn_q;
    // zero-filled left shift leaves mosi low once command and address are out
    assign flash_mosi = sh_q[ADDR_BITS+7];

    always_comb begin
        state_d = state_q;
        sh_d = sh_q;
        bit_d = bit_q;
        rem_d = rem_q;
        rx_d = rx_q;
        out_data_d = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        csn_d = csn_q;
        done_d = 1'b0;
        csh_d = csh_q;
        div_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = CMD;
                        csn_d = 1'b0;
                        sh_d = {CMD_READ, addr};
                        rem_d = len;
                        bit_d = '0;
                    end
                end
            end
            CMD, ADDR: begin
                if (fall) begin
                    sh_d = sh_q << 1;
                    bit_d = bit_q + 5'd1;
                    state_d = bit_q == 5'd31 ? DATA : bit_q >= 5'd7 ? ADDR : CMD;
                end
            end
            DATA: begin
                if (rise) begin
                    if (rem_q == '0) begin
                        csn_d = 1'b1;
                        div_clr = 1'b1;
                        csh_d = '0;
                        state_d = CSH;
                    end else if (bit_q == '0 && out_valid_q && !out_ready) begin
                        div_clr = 1'b1;
                        state_d = STALL;
                    end else begin
                        rx_d = {rx_q[5:0], flash_miso};
                        bit_d = bit_q + 5'd1;
                        if (bit_q == 5'd7) begin
                            out_data_d = {rx_q, flash_miso};
                            out_valid_d = 1'b1;
                            rem_d = rem_q - 1'b1;
                            bit_d = '0;
                        end
                    end
                end
            end
            STALL: state_d = out_valid_q ? STALL : DATA;
            CSH: begin
                if (csh_q != HW'(CSH_CYCLES - 1)) begin
                    csh_d = csh_q + 1'b1;
                end else if (!out_valid_q) begin
                    state_d = IDLE;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q <= '0;
            bit_q <= '0;
            rem_q <= '0;
            rx_q <= '0;
            out_data_q <= '0;
            out_valid_q <= 1'b0;
            csn_q <= 1'b1;
            done_q <= 1'b0;
            csh_q <= '0;
        end else begin
            state_q <= state_d;
            sh_q <= sh_d;
            bit_q <= bit_d;
            rem_q <= rem_d;
            rx_q <= rx_d;
            out_data_q <= out_data_d;
            out_valid_q <= out_valid_d;
            csn_q <= csn_d;
            done_q <= done_d;
            csh_q <= csh_d;
        end
    end
endmodule
